// File: rtl/song_player.sv
// Song ROM sequencer: fetches (note, duration) pairs for the selected song and
// plays each note for its duration followed by a silent articulation gap.
module song_player #(
    parameter int ADDR_W     = 9,
    parameter int NOTE_W     = 4,
    parameter int DUR_W      = 32,
    parameter int GAP_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic [3:0]        song_sel,
    output logic [ADDR_W-1:0] rom_address,
    output logic [3:0]        rom_song,
    input  logic [NOTE_W-1:0] rom_note,
    input  logic [DUR_W-1:0]  rom_duration,
    output logic [NOTE_W-1:0] note_out,
    output logic              playing,
    output logic [ADDR_W-1:0] note_index,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [DUR_W-1:0] GAP_LOAD = HAS_GAP ? DUR_W'(GAP_CYCLES - 1) : '0;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
    logic [3:0]          rom_song_q, rom_song_d;
    logic [NOTE_W-1:0]   note_out_q, note_out_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [ADDR_W-1:0]   note_index_q, note_index_d;
    logic [DUR_W-1:0]    counter_q, counter_d;
    logic                done_q, done_d;
    logic                playing_q, playing_d;
    logic                advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rom_address_q <= '0;
            rom_song_q    <= '0;
            note_out_q    <= '0;
            note_q        <= '0;
            note_index_q  <= '0;
            counter_q     <= '0;
            done_q        <= 1'b0;
            playing_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_address_q <= rom_address_d;
            rom_song_q    <= rom_song_d;
            note_out_q    <= note_out_d;
            note_q        <= note_d;
            note_index_q  <= note_index_d;
            counter_q     <= counter_d;
            done_q        <= done_d;
            playing_q     <= playing_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rom_address_d = rom_address_q;
        rom_song_d    = rom_song_q;
        note_out_d    = note_out_q;
        note_d        = note_q;
        note_index_d  = note_index_q;
        counter_d     = counter_q;
        done_d        = 1'b0;
        advance       = 1'b0;

        if (state_q == S_IDLE) begin
            note_out_d = '0;
            if (start && !stop) begin
                rom_song_d    = song_sel;
                rom_address_d = '0;
                state_d       = S_FETCH;
            end
        end else if (stop) begin
            state_d       = S_IDLE;
            note_out_d    = '0;
            rom_address_d = '0;
        end else if (pause) begin
            // Everything freezes; the latched note comes back once pause drops.
            note_out_d = '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (rom_duration == '0) begin
                        state_d = S_DONE;
                    end else begin
                        note_d       = rom_note;
                        note_out_d   = rom_note;
                        note_index_d = rom_address_q;
                        counter_d    = rom_duration - 1'b1;
                        state_d      = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (counter_q == '0) begin
                        note_out_d = '0;
                        if (HAS_GAP) begin
                            counter_d = GAP_LOAD;
                            state_d   = S_GAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        counter_d  = counter_q - 1'b1;
                        note_out_d = note_q;
                    end
                end
                S_GAP: begin
                    note_out_d = '0;
                    if (counter_q == '0) begin
                        advance = 1'b1;
                    end else begin
                        counter_d = counter_q - 1'b1;
                    end
                end
                S_DONE: begin
                    if (loop) begin
                        rom_address_d = '0;
                        state_d       = S_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // The last ROM address ends the song rather than wrapping to 0.
        if (advance) begin
            if (rom_address_q == '1) begin
                state_d = S_DONE;
            end else begin
                rom_address_d = rom_address_q + 1'b1;
                state_d       = S_FETCH;
            end
        end

        playing_d = (state_d != S_IDLE);
    end

    assign rom_address = rom_address_q;
    assign rom_song    = rom_song_q;
    assign note_out    = note_out_q;
    assign playing     = playing_q;
    assign note_index  = note_index_q;
    assign done        = done_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: one instance with a 2-cycle gap, one with no gap,
// both fed by a small combinational song ROM model.
module tb_song_player;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        loop = 1'b0;
    logic [3:0]  song_sel = 4'd0;

    logic [8:0]  a_rom_address, b_rom_address;
    logic [3:0]  a_rom_song, b_rom_song;
    logic [3:0]  a_rom_note, b_rom_note;
    logic [31:0] a_rom_duration, b_rom_duration;
    logic [3:0]  a_note_out, b_note_out;
    logic        a_playing, b_playing;
    logic [8:0]  a_note_index, b_note_index;
    logic        a_done, b_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    song_player #(.ADDR_W(9), .NOTE_W(4), .DUR_W(32), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop), .pause(pause), .loop(loop),
        .song_sel(song_sel), .rom_address(a_rom_address), .rom_song(a_rom_song),
        .rom_note(a_rom_note), .rom_duration(a_rom_duration), .note_out(a_note_out),
        .playing(a_playing), .note_index(a_note_index), .done(a_done)
    );

    song_player #(.ADDR_W(9), .NOTE_W(4), .DUR_W(32), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop), .pause(pause), .loop(loop),
        .song_sel(song_sel), .rom_address(b_rom_address), .rom_song(b_rom_song),
        .rom_note(b_rom_note), .rom_duration(b_rom_duration), .note_out(b_note_out),
        .playing(b_playing), .note_index(b_note_index), .done(b_done)
    );

    // Song 0: empty. Song 2: (3,3),(5,5),end. Song 4: (7,1),(9,1),end.
    // Song 5: every address holds a 1-cycle note, no end marker.
    function automatic void rom_lookup(input logic [3:0] song, input logic [8:0] addr,
                                       output logic [3:0] note, output logic [31:0] dur);
        note = 4'd0;
        dur  = 32'd0;
        case (song)
            4'd2: begin
                if (addr == 9'd0) begin note = 4'd3; dur = 32'd3; end
                else if (addr == 9'd1) begin note = 4'd5; dur = 32'd5; end
                else note = 4'hF;
            end
            4'd4: begin
                if (addr == 9'd0) begin note = 4'd7; dur = 32'd1; end
                else if (addr == 9'd1) begin note = 4'd9; dur = 32'd1; end
            end
            4'd5: begin
                note = 4'(addr % 15) + 4'd1;
                dur  = 32'd1;
            end
            default: ;
        endcase
    endfunction

    always_comb rom_lookup(a_rom_song, a_rom_address, a_rom_note, a_rom_duration);
    always_comb rom_lookup(b_rom_song, b_rom_address, b_rom_note, b_rom_duration);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        tick();
        checks++;
        if (a_note_out !== 4'd0 || a_playing !== 1'b0 || a_rom_address !== 9'd0 ||
            a_rom_song !== 4'd0 || a_note_index !== 9'd0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state note=%0d playing=%0b addr=%0d song=%0d idx=%0d done=%0b expected all zero",
                     a_note_out, a_playing, a_rom_address, a_rom_song, a_note_index, a_done);
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs zero after reset");
    endtask

    task automatic test_song2();
        logic [3:0] exp_notes [15] = '{3, 3, 3, 0, 0, 0, 5, 5, 5, 5, 5, 0, 0, 0, 0};
        song_sel = 4'd2;
        start_a  = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if (a_rom_song !== 4'd2 || a_playing !== 1'b1) begin
            errors++;
            $display("FAIL song2_start rom_song=%0d playing=%0b expected 2/1", a_rom_song, a_playing);
        end
        for (int i = 0; i < 15; i++) begin
            if (i == 3) begin start_a = 1'b1; song_sel = 4'd4; end
            if (i == 4) start_a = 1'b0;
            tick();
            checks++;
            if (a_note_out !== exp_notes[i] || a_done !== 1'b0) begin
                errors++;
                $display("FAIL song2_note cycle=%0d note=%0d done=%0b expected note=%0d done=0",
                         i + 2, a_note_out, a_done, exp_notes[i]);
            end
            if (i == 0 || i == 6) begin
                checks++;
                if (a_note_index !== ((i == 0) ? 9'd0 : 9'd1)) begin
                    errors++;
                    $display("FAIL song2_index cycle=%0d got=%0d expected=%0d",
                             i + 2, a_note_index, (i == 0) ? 0 : 1);
                end
            end
        end
        tick();
        checks++;
        if (a_done !== 1'b1 || a_playing !== 1'b0 || a_rom_song !== 4'd2) begin
            errors++;
            $display("FAIL song2_done done=%0b playing=%0b rom_song=%0d expected 1/0/2",
                     a_done, a_playing, a_rom_song);
        end
        tick();
        checks++;
        if (a_done !== 1'b0) begin
            errors++;
            $display("FAIL song2_done_pulse done=%0b expected 0", a_done);
        end
        $display("song2: note sequence, indices and done pulse checked");
    endtask

    task automatic test_loop();
        loop     = 1'b1;
        song_sel = 4'd2;
        start_a  = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            checks++;
            if (a_done !== 1'b0) begin
                errors++;
                $display("FAIL loop_no_done cycle=%0d done=%0b expected 0", i, a_done);
            end
        end
        tick();
        checks++;
        if (a_rom_address !== 9'd0 || a_done !== 1'b0 || a_playing !== 1'b1) begin
            errors++;
            $display("FAIL loop_restart addr=%0d done=%0b playing=%0b expected 0/0/1",
                     a_rom_address, a_done, a_playing);
        end
        tick();
        checks++;
        if (a_note_out !== 4'd3) begin
            errors++;
            $display("FAIL loop_note note=%0d expected 3", a_note_out);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop = 1'b0;
        checks++;
        if (a_note_out !== 4'd0 || a_playing !== 1'b0 || a_rom_address !== 9'd0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL loop_stop note=%0d playing=%0b addr=%0d done=%0b expected all 0",
                     a_note_out, a_playing, a_rom_address, a_done);
        end
        $display("loop: restart at address 0 and stop checked");
    endtask

    task automatic test_empty();
        logic [2:0] exp_done = 3'b100;
        song_sel = 4'd0;
        start_a  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            start_a = 1'b0;
            checks++;
            if (a_done !== exp_done[i] || a_note_out !== 4'd0) begin
                errors++;
                $display("FAIL empty_done cycle=%0d done=%0b note=%0d expected done=%0b note=0",
                         i + 1, a_done, a_note_out, exp_done[i]);
            end
        end
        tick();
        checks++;
        if (a_done !== 1'b0 || a_playing !== 1'b0) begin
            errors++;
            $display("FAIL empty_after done=%0b playing=%0b expected 0/0", a_done, a_playing);
        end
        $display("empty: done pulse 3 cycles after start edge");
    endtask

    task automatic test_pause();
        int high = 0;
        song_sel = 4'd2;
        start_a  = 1'b1;
        tick();
        start_a = 1'b0;
        for (int t = 2; t <= 20; t++) begin
            tick();
            if (a_note_out == 4'd5) high++;
            if (t >= 11 && t <= 14) begin
                checks++;
                if (a_note_out !== 4'd0) begin
                    errors++;
                    $display("FAIL pause_silent cycle=%0d note=%0d expected 0", t, a_note_out);
                end
            end
            if (t == 15) begin
                checks++;
                if (a_note_out !== 4'd5) begin
                    errors++;
                    $display("FAIL pause_resume note=%0d expected 5", a_note_out);
                end
            end
            if (t == 10) pause = 1'b1;
            if (t == 14) pause = 1'b0;
        end
        checks++;
        if (high != 5) begin
            errors++;
            $display("FAIL pause_duration high_cycles=%0d expected 5", high);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (a_done !== 1'b0 || a_playing !== 1'b0) begin
            errors++;
            $display("FAIL pause_stop done=%0b playing=%0b expected 0/0", a_done, a_playing);
        end
        $display("pause: note-5 high for %0d unpaused cycles", high);
    endtask

    task automatic test_async_reset();
        song_sel = 4'd2;
        start_a  = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_note_out !== 4'd0 || a_playing !== 1'b0 || a_rom_address !== 9'd0 ||
            a_rom_song !== 4'd0 || a_note_index !== 9'd0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset note=%0d playing=%0b addr=%0d song=%0d idx=%0d done=%0b expected all zero",
                     a_note_out, a_playing, a_rom_address, a_rom_song, a_note_index, a_done);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_done !== 1'b0 || a_playing !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet cycle=%0d done=%0b playing=%0b expected 0/0", i, a_done, a_playing);
            end
        end
        stop    = 1'b1;
        start_a = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if (a_playing !== 1'b0) begin
            errors++;
            $display("FAIL stop_start_idle playing=%0b expected 0", a_playing);
        end
        tick();
        start_a = 1'b0;
        tick();
        checks++;
        if (a_note_out !== 4'd3 || a_note_index !== 9'd0 || a_rom_address !== 9'd0) begin
            errors++;
            $display("FAIL reset_restart note=%0d idx=%0d addr=%0d expected 3/0/0",
                     a_note_out, a_note_index, a_rom_address);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        $display("async_reset: outputs cleared mid-note, replay from address 0");
    endtask

    task automatic test_gap0();
        logic [3:0] exp_notes [4] = '{7, 0, 9, 0};
        song_sel = 4'd4;
        start_b  = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (b_note_out !== exp_notes[i]) begin
                errors++;
                $display("FAIL gap0_note cycle=%0d note=%0d expected %0d", i + 2, b_note_out, exp_notes[i]);
            end
        end
        tick();
        tick();
        checks++;
        if (b_done !== 1'b1 || b_playing !== 1'b0) begin
            errors++;
            $display("FAIL gap0_done done=%0b playing=%0b expected 1/0", b_done, b_playing);
        end
        tick();
        $display("gap0: notes separated only by the fetch cycle");
    endtask

    task automatic test_last_address();
        int cycles;
        song_sel = 4'd5;
        start_b  = 1'b1;
        tick();
        start_b = 1'b0;
        cycles  = 1;
        while (b_done !== 1'b1 && cycles < 1100) begin
            tick();
            cycles++;
        end
        checks++;
        if (b_done !== 1'b1 || cycles != 1026) begin
            errors++;
            $display("FAIL last_addr_done done=%0b cycles=%0d expected done=1 at cycle 1026", b_done, cycles);
        end
        checks++;
        if (b_note_index !== 9'd511 || b_rom_address !== 9'd511 || b_playing !== 1'b0) begin
            errors++;
            $display("FAIL last_addr_nowrap idx=%0d addr=%0d playing=%0b expected 511/511/0",
                     b_note_index, b_rom_address, b_playing);
        end
        tick();
        checks++;
        if (b_done !== 1'b0) begin
            errors++;
            $display("FAIL last_addr_pulse done=%0b expected 0", b_done);
        end
        $display("last_address: song ended at address 511 after %0d cycles", cycles);
    endtask

    initial begin
        test_reset();
        test_song2();
        test_loop();
        test_empty();
        test_pause();
        test_async_reset();
        test_gap0();
        test_last_address();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
